// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped instruction cache with byte-serial refill.
// Hits return a registered word one edge after lookup; misses fill a whole line.
module icache_direct_mapped #(
    parameter int LINE_BYTES_LOG = 4,
    parameter int LINES_LOG      = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_in,
    input  logic [31:0] req_pc,
    input  logic        req_valid,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_grant,
    input  logic        mem_valid,
    input  logic [7:0]  mem_byte
);

    localparam int LB    = 1 << LINE_BYTES_LOG;
    localparam int LINES = 1 << LINES_LOG;
    localparam int IDX_L = LINE_BYTES_LOG;
    localparam int TAG_L = LINE_BYTES_LOG + LINES_LOG;
    localparam int TAG_W = 32 - TAG_L;
    localparam int CW    = LINE_BYTES_LOG + 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t state_q, state_d;

    logic [7:0]                data_q [LINES][LB];
    logic [TAG_W-1:0]          tag_q  [LINES];
    logic [LINES-1:0]          valid_q;
    logic [31:0]               line_base_q;
    logic [CW-1:0]             issue_cnt_q;
    logic [CW-1:0]             recv_cnt_q;
    logic [31:0]               inst_out_q;
    logic                      inst_valid_q;

    logic [LINES_LOG-1:0]      pc_idx;
    logic [TAG_W-1:0]          pc_tag;
    logic [LINE_BYTES_LOG-1:0] pc_off;
    logic [LINES_LOG-1:0]      fill_idx;
    logic                      hit;
    logic                      miss;
    logic                      last_byte;

    // Address decode; the low two pc bits are forced to zero (word aligned).
    always_comb begin
        pc_idx    = req_pc[TAG_L-1:IDX_L];
        pc_tag    = req_pc[31:TAG_L];
        pc_off    = req_pc[LINE_BYTES_LOG-1:0] & ~LINE_BYTES_LOG'(3);
        fill_idx  = line_base_q[TAG_L-1:IDX_L];
        hit       = (state_q == IDLE) && req_valid && valid_q[pc_idx]
                    && (tag_q[pc_idx] == pc_tag);
        miss      = (state_q == IDLE) && req_valid && !hit;
        last_byte = (state_q == FILL) && mem_valid
                    && (recv_cnt_q == CW'(LB - 1));
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (flush_in) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (miss)      state_d = FILL;
                FILL:    if (last_byte) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: memory request while bytes remain to be issued.
    always_comb begin
        mem_req  = (state_q == FILL) && (issue_cnt_q < CW'(LB));
        mem_addr = line_base_q + 32'(issue_cnt_q);
    end

    // Lookup result, fill counters, tags and valid bits.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q      <= '0;
            line_base_q  <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            inst_out_q   <= '0;
            inst_valid_q <= 1'b0;
        end else if (flush_in) begin
            valid_q      <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        inst_out_q <= {
                            data_q[pc_idx][pc_off + LINE_BYTES_LOG'(3)],
                            data_q[pc_idx][pc_off + LINE_BYTES_LOG'(2)],
                            data_q[pc_idx][pc_off + LINE_BYTES_LOG'(1)],
                            data_q[pc_idx][pc_off]
                        };
                        inst_valid_q <= 1'b1;
                    end else begin
                        inst_valid_q <= 1'b0;
                    end
                    if (miss) begin
                        line_base_q     <= {req_pc[31:IDX_L], IDX_L'(0)};
                        issue_cnt_q     <= '0;
                        recv_cnt_q      <= '0;
                        valid_q[pc_idx] <= 1'b0;
                    end
                end
                FILL: begin
                    inst_valid_q <= 1'b0;
                    if (mem_req && mem_grant) begin
                        issue_cnt_q <= issue_cnt_q + CW'(1);
                    end
                    if (mem_valid) begin
                        recv_cnt_q <= recv_cnt_q + CW'(1);
                    end
                    if (last_byte) begin
                        tag_q[fill_idx]   <= line_base_q[31:TAG_L];
                        valid_q[fill_idx] <= 1'b1;
                    end
                end
                default: inst_valid_q <= 1'b0;
            endcase
        end
    end

    // Line data storage; bytes land in arrival order during a fill.
    always_ff @(posedge clk_in) begin
        if (!rst_in && !flush_in && (state_q == FILL) && mem_valid) begin
            data_q[fill_idx][recv_cnt_q[LINE_BYTES_LOG-1:0]] <= mem_byte;
        end
    end

    assign inst_out   = inst_out_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, multi-line instruction cache between the instruction fetcher and the memory controller.
- Generalises the single-window fetch buffer: parametrised line count and line size, tag/valid per line, and flush support.
- Refill is byte-serial over the memory controller's byte port, using a grant/valid handshake so LSB traffic can preempt it.

Parameters:
- LINE_BYTES_LOG, 4, log2 bytes per line (16 B lines by default); must be >= 2.
- LINES_LOG, 4, log2 number of lines (16 lines by default).
- Derived: LINE_BYTES = 2^LINE_BYTES_LOG.
- Derived: offset = pc[LINE_BYTES_LOG-1:0].
- Derived: index = pc[LINE_BYTES_LOG+LINES_LOG-1:LINE_BYTES_LOG].
- Derived: tag = pc[31:LINE_BYTES_LOG+LINES_LOG].

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  synchronous, active-high reset.
- flush_in  in  1  invalidate all lines (fence.i / branch-flush use).
- req_pc  in  32  fetch address; bits [1:0] are ignored and treated as 0.
- req_valid  in  1  fetch request present this cycle.
- inst_out  out  32  little-endian instruction word, registered.
- inst_valid  out  1  inst_out holds the word for the req_pc sampled on the previous edge.
- mem_req  out  1  cache wants a byte at mem_addr.
- mem_addr  out  32  byte address for the next issue: line_base + issue_cnt.
- mem_grant  in  1  controller accepted mem_addr this cycle.
- mem_valid  in  1  byte returned; always exactly one cycle after a grant.
- mem_byte  in  8  returned byte data.

Behaviour:
- Reset: all valid bits 0, state IDLE, inst_valid 0, inst_out 0, mem_req 0, mem_addr 0, counters 0.
  - Reset overrides everything, including a fill in progress.
- Storage: LINES x LINE_BYTES byte array, a tag array, and a valid bit vector.
- IDLE, each edge:
  - Hit (req_valid, valid[index], tag match): inst_out <= bytes {off+3, off+2, off+1, off}; inst_valid <= 1. Single-cycle hit latency.
  - Miss: inst_valid <= 0; line_base <= {pc[31:LINE_BYTES_LOG], 0}; issue_cnt, recv_cnt <= 0; valid[index] <= 0; state <= FILL.
  - req_valid low: inst_valid <= 0, no fill started.
  - mem_valid seen in IDLE is discarded.
- FILL:
  - mem_req = (issue_cnt < LINE_BYTES); mem_addr = line_base + issue_cnt.
  - issue_cnt advances only on mem_grant && mem_req.
  - On mem_valid: write mem_byte to data[line index][recv_cnt]; recv_cnt increments.
  - On mem_valid with recv_cnt == LINE_BYTES-1: write tag, set valid, state <= IDLE.
  - inst_valid held 0 throughout FILL.
- Counters are LINE_BYTES_LOG+1 bits wide; mem_addr wraps mod 2^32.
- req_pc may change during FILL: the fill always completes for the captured line_base, and lookup resumes in IDLE using the current req_pc.
- Fill latency with mem_grant continuously high, where E0 is the miss-detect edge:
  - Grants sampled at E1..E(LINE_BYTES).
  - Bytes sampled at E2..E(LINE_BYTES+1); IDLE after E(LINE_BYTES+1).
  - Hit registered at E(LINE_BYTES+2).
- flush_in (any state):
  - Next edge: all valid bits <= 0, inst_valid <= 0, state <= IDLE, counters <= 0.
  - mem_req drops in the following cycle.
  - An in-flight byte (granted on the flush edge) arrives while in IDLE and is discarded.
  - The aborted line stays invalid.
- flush_in together with a hit on the same edge: the flush wins and inst_valid <= 0.
- Back-to-back fills: a new miss may be detected on the first IDLE edge after a fill; a stray mem_valid cannot occur there.

Test Plan (defaults; memory model byte[a] = a[7:0], grant every cycle unless stated):
- Reset, req_valid=1, req_pc=0x100 -> mem_addr sequences 0x100..0x10F, mem_req drops after 16 grants; inst_valid=1, inst_out=0x03020100 at E18 (18 edges after miss detect).
- Then req_pc=0x104 -> inst_out=0x07060504 with inst_valid next edge; mem_req stays 0.
- req_pc=0x200 (same index 0, different tag) -> refill 0x200..0x20F, inst_out=0x03020100; then req_pc=0x100 misses again and refills.
- During a fill, mem_grant low every other cycle -> mem_addr advances only on granted cycles, 16 bytes written in order, correct word at line completion.
- flush_in for one cycle after 5 bytes received -> mem_req=0 one cycle later, stray byte ignored; re-request 0x100 refetches from 0x100 and returns 0x03020100.
- req_valid=0 with a cold cache -> mem_req stays 0 and inst_valid stays 0 indefinitely.
